// File: rtl/imem_prog_loader.sv
// Byte-stream program loader: frames SYNC,N_lo,N_hi,N*4 data,CSUM into imem words; gates core reset.
// Latency: imem write one cycle after the 4th byte of a word; done/error one cycle after the CSUM byte.
// Backpressure: in_ready is registered, high in every loading state; low in DONE/ERROR until restart.
module imem_prog_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    // Largest legal word count; one bit wider than N so 2**16 never aliases.
    localparam logic [16:0] MAX_N = 17'd1 << ADDR_W;

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic [7:0]  csum;

    logic        xfer;
    logic [15:0] n_full;
    logic [7:0]  csum_nxt;

    assign xfer     = in_valid & in_ready;
    assign n_full   = {in_data, cnt[7:0]};
    assign csum_nxt = csum ^ in_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            cnt        <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            csum       <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (xfer && in_data == SYNC_BYTE) begin
                        csum  <= '0;
                        state <= S_CNT_LO;
                    end
                end
                S_CNT_LO: begin
                    if (xfer) begin
                        cnt[7:0] <= in_data;
                        csum     <= in_data;
                        state    <= S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    if (xfer) begin
                        cnt[15:8] <= in_data;
                        csum      <= csum_nxt;
                        word_idx  <= '0;
                        byte_idx  <= '0;
                        if ({1'b0, n_full} > MAX_N) begin
                            state    <= S_ERROR;
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                        end else if (n_full == 16'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        csum     <= csum_nxt;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_idx[ADDR_W-1:0];
                            imem_wdata <= {in_data, word_buf};
                            word_idx   <= word_idx + 16'd1;
                            if (word_idx == cnt - 16'd1)
                                state <= S_CSUM;
                        end else begin
                            word_buf[8*byte_idx +: 8] <= in_data;
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        if (in_data == csum) begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            core_reset <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (restart) begin
                        state      <= S_IDLE;
                        done       <= 1'b0;
                        core_reset <= 1'b1;
                        in_ready   <= 1'b1;
                    end
                end
                S_ERROR: begin
                    if (restart) begin
                        state    <= S_IDLE;
                        error    <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_prog_loader.sv
// Directed frames for the imem program loader; imem writes are scoreboarded against a queue.
module tb_imem_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        restart;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    imem_prog_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .restart    (restart),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    int          nvec = 0;
    int          nerr = 0;
    wr_t         exp_q[$];
    logic [31:0] words[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && imem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write",
                             imem_addr, imem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", {24'd0, imem_addr}, {24'd0, e.addr});
                    chk("wr_data", imem_wdata, e.data);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        if (gap) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            nvec++;
            nerr++;
            $display("FAIL send_timeout: byte %h in_ready %b expected 1", b, in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends a frame carrying words[0..n-1]; corrupt flips bit 0 of the checksum.
    task automatic load(input logic [15:0] n, input bit corrupt, input bit gaps);
        logic [7:0]  cs;
        logic [7:0]  b;
        logic [31:0] w;
        cs = n[7:0] ^ n[15:8];
        send_byte(8'hA5, gaps);
        send_byte(n[7:0], gaps);
        send_byte(n[15:8], gaps);
        for (int i = 0; i < int'(n); i++) begin
            w = words[i];
            exp_q.push_back('{addr: 8'(i), data: w});
            for (int k = 0; k < 4; k++) begin
                b  = w[8*k +: 8];
                cs = cs ^ b;
                send_byte(b, gaps);
            end
        end
        send_byte(cs ^ {7'd0, corrupt}, gaps);
        in_valid = 1'b0;
    endtask

    task automatic check_end(input string tag, input bit exp_done);
        chk({tag, "_done"},       {31'd0, done},       {31'd0, exp_done});
        chk({tag, "_error"},      {31'd0, error},      {31'd0, !exp_done});
        chk({tag, "_core_reset"}, {31'd0, core_reset}, {31'd0, !exp_done});
        chk({tag, "_in_ready"},   {31'd0, in_ready},   32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_pending_writes"}, exp_q.size(), 32'd0);
    endtask

    task automatic do_restart(input string tag);
        @(posedge clk);
        #1 restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        chk({tag, "_rst_done"},       {31'd0, done},       32'd0);
        chk({tag, "_rst_error"},      {31'd0, error},      32'd0);
        chk({tag, "_rst_core_reset"}, {31'd0, core_reset}, 32'd1);
        chk({tag, "_rst_in_ready"},   {31'd0, in_ready},   32'd1);
    endtask

    task automatic frame1();
        words = '{32'h0000_0013, 32'h0010_0093};
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        restart  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready",   {31'd0, in_ready},   32'd0);
        chk("reset_core_reset", {31'd0, core_reset}, 32'd1);
        chk("reset_done",       {31'd0, done},       32'd0);
        chk("reset_error",      {31'd0, error},      32'd0);
        chk("reset_we",         {31'd0, imem_we},    32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // 1: good two-word frame
        frame1();
        load(16'd2, 1'b0, 1'b0);
        check_end("t1", 1'b1);
        do_restart("t1");

        // 2: bad checksum, then recovery
        frame1();
        load(16'd2, 1'b1, 1'b0);
        check_end("t2bad", 1'b0);
        do_restart("t2");
        load(16'd2, 1'b0, 1'b0);
        check_end("t2good", 1'b1);
        do_restart("t2good");

        // 3: junk bytes dropped in IDLE
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        load(16'd2, 1'b0, 1'b0);
        check_end("t3", 1'b1);
        do_restart("t3");

        // 4: oversize count rejected right after CNT_HI
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        in_valid = 1'b0;
        check_end("t4", 1'b0);
        do_restart("t4");

        // 5: same frame with random valid gaps
        load(16'd2, 1'b0, 1'b1);
        check_end("t5", 1'b1);
        do_restart("t5");

        // Empty image and full-capacity image
        words = {};
        load(16'd0, 1'b0, 1'b0);
        check_end("n0", 1'b1);
        do_restart("n0");
        for (int i = 0; i < 256; i++)
            words.push_back({8'(i + 3), 8'(i * 7), 8'(i ^ 8'h5A), 8'(i)});
        load(16'h0100, 1'b0, 1'b0);
        check_end("nmax", 1'b1);
        do_restart("nmax");

        // 6: reset mid-frame after 6 data bytes
        exp_q.push_back('{addr: 8'h00, data: 32'h0000_0013});
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h93, 1'b0);
        send_byte(8'h00, 1'b0);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("t6_in_ready",   {31'd0, in_ready},   32'd0);
        chk("t6_we",         {31'd0, imem_we},    32'd0);
        chk("t6_addr",       {24'd0, imem_addr},  32'd0);
        chk("t6_wdata",      imem_wdata,          32'd0);
        chk("t6_core_reset", {31'd0, core_reset}, 32'd1);
        chk("t6_done",       {31'd0, done},       32'd0);
        chk("t6_error",      {31'd0, error},      32'd0);
        chk("t6_pending",    exp_q.size(),        32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        frame1();
        load(16'd2, 1'b0, 1'b0);
        check_end("t6", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
